stream_mux_rr: RTL

- Parametrised N-channel streaming multiplexer. It is the registered, arbitrated successor of the plain 2:1 select mux.
- Each input channel carries WIDTH-bit data with valid/ready/last handshake.
- A round-robin arbiter picks one channel and locks onto it until its packet's last beat has transferred.
- The selected beat is driven through a single output register stage. The block sits between multiple producers and one shared downstream consumer.

---
 rtl/stream_mux_pkg.sv | 36 +++
 rtl/rr_arbiter.sv | 26 ++
 rtl/stream_mux_rr.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/stream_mux_pkg.sv
// Shared types and the round-robin pick function for the stream_mux_rr block.
// Supports up to MAX_CH input channels; the fixed-priority build
// (STREAM_MUX_FIXED_PRIO_EN) reuses rr_pick with a pointer of N_CH-1.
package stream_mux_pkg;

    localparam int MAX_CH   = 32;
    localparam int MAX_CH_W = 5;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    typedef struct packed {
        logic                found;
        logic [MAX_CH_W-1:0] idx;
    } pick_t;

    // First set bit of 'valid' searching upward from ptr+1 with wrap at n_ch.
    function automatic pick_t rr_pick(input logic [MAX_CH-1:0] valid,
                                      input int unsigned       ptr,
                                      input int unsigned       n_ch);
        pick_t               r;
        logic [MAX_CH_W-1:0] c;
        r = '0;
        for (int unsigned k = 1; k <= MAX_CH; k++) begin
            c = MAX_CH_W'((ptr + k) % n_ch);
            if (k <= n_ch && !r.found && valid[c]) begin
                r.found = 1'b1;
                r.idx   = c;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first valid channel after ptr.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter  int N_CH = 4,
    localparam int CH_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] valid,
    input  logic [CH_W-1:0] ptr,
    output logic            found,
    output logic [CH_W-1:0] grant
);

    pick_t pick;
    logic  unused_idx_bits;

    // Search the valid vector starting just after the last winner.
    always_comb begin
        pick = rr_pick(MAX_CH'(valid), 32'(ptr), 32'(N_CH));
    end

    assign found           = pick.found;
    assign grant           = pick.idx[CH_W-1:0];
    assign unused_idx_bits = ^pick.idx;

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel packet-locking stream multiplexer with one registered output stage.
// Default build arbitrates round-robin between packets; defining
// STREAM_MUX_FIXED_PRIO_EN makes the idle arbiter fixed priority (lowest index)
// and removes the round-robin pointer.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int N_CH  = 4,
    localparam int CH_W  = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH-1:0]       in_valid,
    output logic [N_CH-1:0]       in_ready,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_last,
    output logic [CH_W-1:0]       out_ch
);

    state_t            state;
    state_t            state_nxt;
    logic [CH_W-1:0]   lock_ch;
    logic [CH_W-1:0]   idle_grant;
    logic              idle_found;
    logic [CH_W-1:0]   grant;
    logic              grant_vld;
    logic              load;
    logic              xfer;
    logic [WIDTH-1:0]  sel_data;
    logic              sel_last;
    logic              sel_valid;

    assign load = !out_valid || out_ready;
    assign xfer = load && grant_vld && sel_valid;

`ifdef STREAM_MUX_FIXED_PRIO_EN
    pick_t fixed_pick;
    logic  unused_fixed_bits;

    // Fixed priority: searching from N_CH-1 upward means channel 0 is checked first.
    always_comb begin
        fixed_pick = rr_pick(MAX_CH'(in_valid), 32'(N_CH - 1), 32'(N_CH));
    end

    assign idle_found        = fixed_pick.found;
    assign idle_grant        = fixed_pick.idx[CH_W-1:0];
    assign unused_fixed_bits = ^fixed_pick.idx;
`else
    logic [CH_W-1:0] rr_ptr;

    rr_arbiter #(.N_CH(N_CH)) u_arb (
        .valid (in_valid),
        .ptr   (rr_ptr),
        .found (idle_found),
        .grant (idle_grant)
    );

    // Remember the channel whose packet just finished so it goes to the back of the line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= CH_W'(N_CH - 1);
        end else if (xfer && sel_last) begin
            rr_ptr <= grant;
        end
    end
`endif

    // State register for the packet lock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Lock after a non-final beat, unlock after the final one.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (xfer && !sel_last) state_nxt = LOCKED;
            LOCKED:  if (xfer && sel_last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant comes from the arbiter when idle and is pinned to lock_ch when locked.
    always_comb begin
        grant     = idle_grant;
        grant_vld = idle_found;
        if (state == LOCKED) begin
            grant     = lock_ch;
            grant_vld = 1'b1;
        end
    end

    // Route the granted channel and raise its ready when the output stage can load.
    always_comb begin
        in_ready  = '0;
        sel_data  = '0;
        sel_last  = 1'b0;
        sel_valid = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant == CH_W'(i)) begin
                sel_data    = in_data[i*WIDTH +: WIDTH];
                sel_last    = in_last[i];
                sel_valid   = in_valid[i];
                in_ready[i] = load && grant_vld;
            end
        end
    end

    // Capture which channel owns the packet when its first beat moves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_ch <= '0;
        end else if (state == IDLE && xfer && !sel_last) begin
            lock_ch <= grant;
        end
    end

    // Output register: load on an input transfer, otherwise drain when downstream takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_ch    <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_last  <= sel_last;
            out_ch    <= grant;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
